// File: rtl/pe_addr_gen_ram.sv
// LDPC PE storage core: three circular edge-address generators, three lock-step
// extrinsic RAM banks and a ping-pong hard-decision RAM pair. Optional PE_ADDR_WRAP_FLAG_EN adds ag_last.
`timescale 1ns/1ps

module pe_addr_gen_ram_bank #(
    parameter int AW    = 5,
    parameter int DW    = 6,
    parameter int DEPTH = 1 << AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs_i,
    input  logic          we_i,
    input  logic [AW-1:0] add_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] data_o
);
    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] data_q;

    // Reset wipes the whole array so a new code block never sees stale messages.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            data_q <= '0;
        end else if (cs_i) begin
            if (we_i) mem_q[add_i] <= data_i;
            else      data_q       <= mem_q[add_i];
        end
    end

    assign data_o = data_q;
endmodule

module pe_addr_gen_ram #(
    parameter int L              = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int RAM_DEPTH      = 1 << ADDR_WIDTH,
    parameter int COUNT_FROM_1   = 0,
    parameter int COUNT_FROM_2   = 0,
    parameter int COUNT_FROM_3   = 0,
    parameter int MESSAGE_WIDTH  = 5,
    parameter int DECISION_WIDTH = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             ag_en,
    input  logic                             ag_clear,
    output logic [3*ADDR_WIDTH-1:0]          ag_out,
`ifdef PE_ADDR_WRAP_FLAG_EN
    output logic                             ag_last,
`endif
    input  logic [3*ADDR_WIDTH-1:0]          ext_add,
    input  logic                             ext_we,
    input  logic                             ext_cs,
    input  logic [3*(MESSAGE_WIDTH+1)-1:0]   ext_data_in,
    output logic [3*(MESSAGE_WIDTH+1)-1:0]   ext_data_out,
    input  logic [2*ADDR_WIDTH-1:0]          dec_add,
    input  logic [1:0]                       dec_we,
    input  logic [1:0]                       dec_cs,
    input  logic [2*DECISION_WIDTH-1:0]      dec_data_in,
    output logic [2*DECISION_WIDTH-1:0]      dec_data_out
);
    localparam int EW = MESSAGE_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] AG_LAST = ADDR_WIDTH'(L - 1);
    localparam logic [2:0][ADDR_WIDTH-1:0] AG_START = {
        ADDR_WIDTH'(COUNT_FROM_3), ADDR_WIDTH'(COUNT_FROM_2), ADDR_WIDTH'(COUNT_FROM_1)};

    logic [2:0][ADDR_WIDTH-1:0] ag_q, ag_d;

    // Generators always move together, so their start offsets stay fixed relative to each other.
    always_comb begin
        ag_d = ag_q;
        if (ag_clear) begin
            ag_d = AG_START;
        end else if (ag_en) begin
            for (int i = 0; i < 3; i++)
                ag_d[i] = (ag_q[i] == AG_LAST) ? '0 : ag_q[i] + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ag_q <= AG_START;
        else       ag_q <= ag_d;
    end

    assign ag_out = ag_q;

`ifdef PE_ADDR_WRAP_FLAG_EN
    assign ag_last = (ag_q[0] == AG_LAST);
`endif

    for (genvar i = 0; i < 3; i++) begin : g_ext
        pe_addr_gen_ram_bank #(.AW(ADDR_WIDTH), .DW(EW), .DEPTH(RAM_DEPTH)) u_bank (
            .clk    (clk),
            .reset  (reset),
            .cs_i   (ext_cs),
            .we_i   (ext_we),
            .add_i  (ext_add[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .data_i (ext_data_in[i*EW +: EW]),
            .data_o (ext_data_out[i*EW +: EW])
        );
    end

    // Decision banks are independent so one frame can be written while the other is read out.
    for (genvar i = 0; i < 2; i++) begin : g_dec
        pe_addr_gen_ram_bank #(.AW(ADDR_WIDTH), .DW(DECISION_WIDTH), .DEPTH(RAM_DEPTH)) u_bank (
            .clk    (clk),
            .reset  (reset),
            .cs_i   (dec_cs[i]),
            .we_i   (dec_we[i]),
            .add_i  (dec_add[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .data_i (dec_data_in[i*DECISION_WIDTH +: DECISION_WIDTH]),
            .data_o (dec_data_out[i*DECISION_WIDTH +: DECISION_WIDTH])
        );
    end
endmodule

// File: tb/tb_pe_addr_gen_ram.sv
// Directed bench for pe_addr_gen_ram with generator offsets 0/5/31 over L=32.
`timescale 1ns/1ps

module tb_pe_addr_gen_ram;
    localparam int AW = 5;
    localparam int EW = 6;

    logic            clk = 1'b0;
    logic            reset;
    logic            ag_en, ag_clear;
    logic [3*AW-1:0] ag_out;
`ifdef PE_ADDR_WRAP_FLAG_EN
    logic            ag_last;
`endif
    logic [3*AW-1:0] ext_add;
    logic            ext_we, ext_cs;
    logic [3*EW-1:0] ext_data_in, ext_data_out;
    logic [2*AW-1:0] dec_add;
    logic [1:0]      dec_we, dec_cs;
    logic [1:0]      dec_data_in, dec_data_out;

    int n_vec = 0;
    int n_err = 0;

    pe_addr_gen_ram #(
        .L(32), .ADDR_WIDTH(AW), .RAM_DEPTH(32),
        .COUNT_FROM_1(0), .COUNT_FROM_2(5), .COUNT_FROM_3(31),
        .MESSAGE_WIDTH(5), .DECISION_WIDTH(1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ag_en        (ag_en),
        .ag_clear     (ag_clear),
        .ag_out       (ag_out),
`ifdef PE_ADDR_WRAP_FLAG_EN
        .ag_last      (ag_last),
`endif
        .ext_add      (ext_add),
        .ext_we       (ext_we),
        .ext_cs       (ext_cs),
        .ext_data_in  (ext_data_in),
        .ext_data_out (ext_data_out),
        .dec_add      (dec_add),
        .dec_we       (dec_we),
        .dec_cs       (dec_cs),
        .dec_data_in  (dec_data_in),
        .dec_data_out (dec_data_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; ag_en = 1'b0; ag_clear = 1'b0;
        ext_add = '0; ext_we = 1'b0; ext_cs = 1'b0; ext_data_in = '0;
        dec_add = '0; dec_we = 2'b00; dec_cs = 2'b00; dec_data_in = 2'b00;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (ag_out !== {5'd31, 5'd5, 5'd0}) begin
            n_err++; $display("FAIL reset_ag_out got=%h exp=%h", ag_out, {5'd31, 5'd5, 5'd0});
        end
        n_vec++;
        if (ext_data_out !== '0 || dec_data_out !== 2'b00) begin
            n_err++; $display("FAIL reset_data_out ext=%h dec=%b exp=0", ext_data_out, dec_data_out);
        end
    endtask

    task automatic test_gen_sequence();
        logic [3*AW-1:0] exp;
        do_reset();
        ag_en = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            exp = {5'((31 + k) % 32), 5'((5 + k) % 32), 5'(k % 32)};
            n_vec++;
            if (ag_out !== exp) begin
                n_err++; $display("FAIL gen_seq k=%0d got=%h exp=%h", k, ag_out, exp);
            end
            tick();
        end
        ag_en = 1'b0;
    endtask

    task automatic test_clear();
        do_reset();
        ag_en = 1'b1;
        repeat (17) tick();
        n_vec++;
        if (ag_out !== {5'd16, 5'd22, 5'd17}) begin
            n_err++; $display("FAIL clear_pre got=%h exp=%h", ag_out, {5'd16, 5'd22, 5'd17});
        end
        ag_clear = 1'b1;
        tick();
        ag_clear = 1'b0;
        n_vec++;
        if (ag_out !== {5'd31, 5'd5, 5'd0}) begin
            n_err++; $display("FAIL clear_reload got=%h exp=%h", ag_out, {5'd31, 5'd5, 5'd0});
        end
        ag_en = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (ag_out !== {5'd31, 5'd5, 5'd0}) begin
            n_err++; $display("FAIL clear_hold got=%h exp=%h", ag_out, {5'd31, 5'd5, 5'd0});
        end
        ag_en = 1'b1;
        tick();
        ag_en = 1'b0;
        n_vec++;
        if (ag_out !== {5'd0, 5'd6, 5'd1}) begin
            n_err++; $display("FAIL clear_step got=%h exp=%h", ag_out, {5'd0, 5'd6, 5'd1});
        end
    endtask

    task automatic test_ext();
        do_reset();
        ext_cs = 1'b1; ext_we = 1'b1;
        ext_add = {5'd30, 5'd7, 5'd3};
        ext_data_in = {6'h3F, 6'h2A, 6'h15};
        tick();
        n_vec++;
        if (ext_data_out !== '0) begin
            n_err++; $display("FAIL ext_write_no_through got=%h exp=0", ext_data_out);
        end
        ext_we = 1'b0;
        ext_data_in = '0;
        tick();
        n_vec++;
        if (ext_data_out !== {6'h3F, 6'h2A, 6'h15}) begin
            n_err++; $display("FAIL ext_read got=%h exp=%h", ext_data_out, {6'h3F, 6'h2A, 6'h15});
        end
        ext_cs = 1'b0;
        ext_add = '0;
        tick();
        n_vec++;
        if (ext_data_out !== {6'h3F, 6'h2A, 6'h15}) begin
            n_err++; $display("FAIL ext_cs0_hold got=%h exp=%h", ext_data_out, {6'h3F, 6'h2A, 6'h15});
        end
        // top address of each bank
        ext_cs = 1'b1; ext_we = 1'b1;
        ext_add = {5'd31, 5'd31, 5'd31};
        ext_data_in = {6'h01, 6'h22, 6'h33};
        tick();
        ext_we = 1'b0;
        tick();
        n_vec++;
        if (ext_data_out !== {6'h01, 6'h22, 6'h33}) begin
            n_err++; $display("FAIL ext_addr31 got=%h exp=%h", ext_data_out, {6'h01, 6'h22, 6'h33});
        end
        ext_add = {5'd3, 5'd30, 5'd7};
        tick();
        n_vec++;
        if (ext_data_out !== '0) begin
            n_err++; $display("FAIL ext_bank_indep got=%h exp=0", ext_data_out);
        end
        ext_cs = 1'b0;
    endtask

    task automatic test_dec();
        do_reset();
        dec_add = {5'd4, 5'd4};
        dec_cs = 2'b11; dec_we = 2'b01; dec_data_in = 2'b01;
        tick();
        n_vec++;
        if (dec_data_out !== 2'b00) begin
            n_err++; $display("FAIL dec_pingpong got=%b exp=00", dec_data_out);
        end
        dec_cs = 2'b01; dec_we = 2'b00; dec_data_in = 2'b00;
        tick();
        n_vec++;
        if (dec_data_out !== 2'b01) begin
            n_err++; $display("FAIL dec_read0 got=%b exp=01", dec_data_out);
        end
        dec_add = {5'd31, 5'd4};
        dec_cs = 2'b10; dec_we = 2'b10; dec_data_in = 2'b10;
        tick();
        dec_cs = 2'b00; dec_we = 2'b00; dec_data_in = 2'b00;
        repeat (2) tick();
        n_vec++;
        if (dec_data_out !== 2'b01) begin
            n_err++; $display("FAIL dec_cs0_hold got=%b exp=01", dec_data_out);
        end
        dec_add = {5'd31, 5'd5};
        dec_cs = 2'b11;
        tick();
        dec_cs = 2'b00;
        n_vec++;
        if (dec_data_out !== 2'b10) begin
            n_err++; $display("FAIL dec_read_both got=%b exp=10", dec_data_out);
        end
    endtask

    task automatic test_midreset();
        do_reset();
        ext_cs = 1'b1; ext_we = 1'b1;
        ext_add = {5'd9, 5'd8, 5'd2};
        ext_data_in = {6'h11, 6'h2C, 6'h3A};
        dec_add = {5'd6, 5'd6}; dec_cs = 2'b11; dec_we = 2'b11; dec_data_in = 2'b11;
        ag_en = 1'b1;
        tick();
        ext_we = 1'b0; dec_we = 2'b00;
        tick();
        ag_en = 1'b0;
        n_vec++;
        if (ext_data_out !== {6'h11, 6'h2C, 6'h3A} || dec_data_out !== 2'b11) begin
            n_err++; $display("FAIL midreset_prefill ext=%h dec=%b", ext_data_out, dec_data_out);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++;
        if (ag_out !== {5'd31, 5'd5, 5'd0} || ext_data_out !== '0 || dec_data_out !== 2'b00) begin
            n_err++; $display("FAIL midreset_out ag=%h ext=%h dec=%b exp=%h/0/0",
                              ag_out, ext_data_out, dec_data_out, {5'd31, 5'd5, 5'd0});
        end
        tick();
        n_vec++;
        if (ext_data_out !== '0 || dec_data_out !== 2'b00) begin
            n_err++; $display("FAIL midreset_mem ext=%h dec=%b exp=0", ext_data_out, dec_data_out);
        end
        ext_cs = 1'b0; dec_cs = 2'b00;
    endtask

`ifdef PE_ADDR_WRAP_FLAG_EN
    task automatic test_wrap_flag();
        do_reset();
        ag_en = 1'b1;
        for (int k = 0; k < 66; k++) begin
            n_vec++;
            if (ag_last !== ((k % 32) == 31)) begin
                n_err++; $display("FAIL wrap_flag k=%0d got=%b exp=%b", k, ag_last, (k % 32) == 31);
            end
            tick();
        end
        ag_en = 1'b0;
    endtask
`endif

    initial begin
        idle();
        tick();
        test_reset();
        test_gen_sequence();
        test_clear();
        test_ext();
        test_dec();
        test_midreset();
`ifdef PE_ADDR_WRAP_FLAG_EN
        test_wrap_flag();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout vectors=%0d", n_vec);
        $fatal(1);
    end
endmodule
